// File: rtl/fifo_level.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fifo_level : FWFT synchronous FIFO, any depth, registered count and level  |
// |              flags. Optional FIFO_ERR_FLAGS_EN adds sticky over/underflow. |
// | Revision   : 1.0                                                           |
// +----------------------------------------------------------------------------+
module fifo_level #(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 2048,
  parameter int AE_LEVEL = 4,
  parameter int AF_LEVEL = 2044
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          soft_rst_i,
  input  logic [WIDTH-1:0]              data_w_i,
  input  logic                          we_i,
  input  logic                          re_i,
  output logic [WIDTH-1:0]              data_r_o,
  output logic                          empty_o,
  output logic                          full_o,
  output logic [$clog2(DEPTH+1)-1:0]    count_o,
  output logic                          almost_empty_o,
  output logic                          almost_full_o
`ifdef FIFO_ERR_FLAGS_EN
  ,
  output logic                          overflow_o,
  output logic                          underflow_o
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [PW-1:0] c_LAST_PTR = PW'(DEPTH - 1);
  localparam logic [CW-1:0] c_FULL_CNT = CW'(DEPTH);
  localparam logic          c_AF_RST   = (AF_LEVEL <= 0);

  logic [WIDTH-1:0] mem [DEPTH];

  logic [PW-1:0]    head_q, head_d;
  logic [PW-1:0]    tail_q, tail_d;
  logic [CW-1:0]    count_q, count_d;
  logic             empty_q, empty_d;
  logic             full_q, full_d;
  logic             ae_q, ae_d;
  logic             af_q, af_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             w_wv, w_rv;
  logic [31:0]      w_count32;

  always_comb begin
    w_wv    = we_i & ~full_q;
    w_rv    = re_i & ~empty_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (w_rv) head_d = (head_q == c_LAST_PTR) ? '0 : head_q + PW'(1);
    if (w_wv) tail_d = (tail_q == c_LAST_PTR) ? '0 : tail_q + PW'(1);
    case ({w_wv, w_rv})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    if (soft_rst_i) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
    w_count32 = 32'(count_d);
    empty_d   = (count_d == '0);
    full_d    = (count_d == c_FULL_CNT);
    ae_d      = (w_count32 <= 32'(AE_LEVEL));
    af_d      = (w_count32 >= 32'(AF_LEVEL));
    // The new head word is either being written this very edge or already in RAM.
    dout_d    = (w_wv && (tail_q == head_d)) ? data_w_i : mem[head_d];
  end

  always_ff @(posedge clk_i) begin
    if (w_wv && !soft_rst_i) mem[tail_q] <= data_w_i;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      empty_q <= 1'b1;
      full_q  <= 1'b0;
      ae_q    <= 1'b1;
      af_q    <= c_AF_RST;
      dout_q  <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      empty_q <= empty_d;
      full_q  <= full_d;
      ae_q    <= ae_d;
      af_q    <= af_d;
      dout_q  <= dout_d;
    end
  end

  assign data_r_o       = dout_q;
  assign empty_o        = empty_q;
  assign full_o         = full_q;
  assign count_o        = count_q;
  assign almost_empty_o = ae_q;
  assign almost_full_o  = af_q;

`ifdef FIFO_ERR_FLAGS_EN
  logic ovf_q, unf_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else if (soft_rst_i) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      if (we_i && full_q)  ovf_q <= 1'b1;
      if (re_i && empty_q) unf_q <= 1'b1;
    end
  end

  assign overflow_o  = ovf_q;
  assign underflow_o = unf_q;
`endif

endmodule
`default_nettype wire
